fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the synchronous instruction memory.
- Owns the PC and drives the memory address.
- Tracks the memory's 1-cycle registered read latency and presents a valid/pc/instruction triple to decode (IF/ID boundary).
- Handles decode stalls with a hold buffer, taken redirects (JMP/CALL/RET) with squash, and a small return-address stack for RET targets.

---
 rtl/fetch_unit_pkg.sv | 35 +++
 rtl/fetch_unit_ras.sv | 79 +++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Constants shared by fetch, decode and the instruction memory: address and
// instruction widths, reset PC, the NOP presented on empty slots and the
// default return-address-stack depth. Also holds the per-edge fetch action
// encoding and the helper that resolves redirect/stall priority.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int              ADDR_W_DEF    = 16;
    localparam int              INSTR_W_DEF   = 16;
    localparam logic [15:0]     RESET_PC_DEF  = 16'h0000;
    localparam logic [15:0]     NOP_INSTR_DEF = 16'hF000;
    localparam int              RAS_DEPTH_DEF = 4;

    // What the fetch stage does on the coming clock edge.
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } fetch_act_e;

    // A redirect always beats a stall: the held instruction is on the wrong
    // path anyway, so there is nothing worth preserving.
    function automatic fetch_act_e fetch_action(input logic redirect,
                                                input logic stall);
        if (redirect)
            return ACT_REDIRECT;
        else if (stall)
            return ACT_STALL;
        else
            return ACT_ADVANCE;
    endfunction

endpackage

// File: rtl/fetch_unit_ras.sv
// ---------------------------------------------------------------------------
// return_addr_stack
// Circular LIFO of return addresses. When full, a push overwrites the oldest
// entry and the count saturates. Popping an empty stack yields RESET_PC and
// raises a one-cycle underflow pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (pointer, count, pulse)
//   push       write push_data as the new top
//   push_data  return address to store
//   pop        remove the top entry (top is valid in the same cycle)
//   top        current top entry, RESET_PC when empty
//   empty      stack holds no entries
//   underflow  registered pulse: the previous cycle popped an empty stack
// ---------------------------------------------------------------------------
module return_addr_stack
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              underflow
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              underflow_q;
    logic [PTR_W-1:0]  wr_ptr;

    assign empty     = (count_q == '0);
    assign top       = empty ? RESET_PC : stack_q[ptr_q];
    assign underflow = underflow_q;

    // Pop+push replaces the current top in place; a plain push goes one
    // slot up (wrapping onto the oldest entry when full).
    assign wr_ptr = pop ? ptr_q : ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= pop && empty;
            if (pop && push) begin
                if (empty)
                    count_q <= CNT_W'(1);
            end else if (pop) begin
                if (!empty) begin
                    ptr_q   <= ptr_q - 1'b1;
                    count_q <= count_q - 1'b1;
                end
            end else if (push) begin
                ptr_q <= ptr_q + 1'b1;
                if (count_q != CNT_W'(RAS_DEPTH))
                    count_q <= count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            stack_q[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage in front of a synchronous instruction memory with a
// one-cycle registered read. Owns the PC, tracks which PC the memory data
// belongs to, buffers the instruction across decode stalls and handles
// redirects (JMP/CALL/RET) by squashing the in-flight fetch. RET targets come
// from a small return-address stack.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_addr         address to instruction memory (the PC register)
//   imem_instruction  memory read data, valid one cycle after imem_addr
//   stall             decode cannot accept; hold if_* stable
//   redirect          taken control transfer; flush and reload PC
//   redirect_target   new PC for a non-RET redirect
//   redirect_is_ret   redirect target comes from the RAS (pop)
//   call_push         push if_pc+1 onto the RAS
//   if_valid/if_pc/if_instr  IF/ID triple; if_instr is NOP_INSTR when invalid
//   ras_empty         RAS holds no entries
//   ras_underflow     one-cycle pulse after a RET popped an empty RAS
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(RESET_PC_DEF),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
    parameter int                 RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instruction,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               redirect_is_ret,
    input  logic               call_push,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               ras_empty,
    output logic               ras_underflow
);

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  resp_pc_q;
    logic               resp_valid_q;
    logic               hold_q;
    logic [INSTR_W-1:0] hold_instr_q;

    fetch_act_e         act;
    logic               ras_pop;
    logic [ADDR_W-1:0]  ras_top;
    logic [ADDR_W-1:0]  ras_push_data;
    logic [ADDR_W-1:0]  next_target;

    assign act           = fetch_action(redirect, stall);
    assign ras_pop       = redirect && redirect_is_ret;
    assign ras_push_data = resp_pc_q + 1'b1;
    assign next_target   = redirect_is_ret ? ras_top : redirect_target;

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_PC  (RESET_PC)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (call_push),
        .push_data (ras_push_data),
        .pop       (ras_pop),
        .top       (ras_top),
        .empty     (ras_empty),
        .underflow (ras_underflow)
    );

    // IF stage boundary: PC -> memory address, memory data -> IF/ID triple.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            resp_pc_q    <= '0;
            resp_valid_q <= 1'b0;
            hold_q       <= 1'b0;
        end else begin
            unique case (act)
                ACT_REDIRECT: begin
                    // The word the memory returns next belongs to the old
                    // path; mark it dead so exactly one bubble appears.
                    pc_q         <= next_target;
                    resp_valid_q <= 1'b0;
                    hold_q       <= 1'b0;
                end
                ACT_STALL: begin
                    hold_q <= 1'b1;
                end
                default: begin
                    resp_pc_q    <= pc_q;
                    resp_valid_q <= 1'b1;
                    pc_q         <= pc_q + 1'b1;
                    hold_q       <= 1'b0;
                end
            endcase
        end
    end

    // Capture the word only on the first stall cycle: afterwards the memory
    // is re-reading pc_q, which is the next instruction, not the held one.
    always_ff @(posedge clk) begin
        if (act == ACT_STALL && !hold_q)
            hold_instr_q <= imem_instruction;
    end

    assign imem_addr = pc_q;
    assign if_pc     = resp_pc_q;
    assign if_valid  = resp_valid_q;
    assign if_instr  = !resp_valid_q ? NOP_INSTR
                     : (hold_q ? hold_instr_q : imem_instruction);

endmodule
